sim_uart_console: RTL and testbench

//  Simulation-side multi-channel UART console monitor for the SoC testbench. Samples N UART TX

---
 rtl/sim_uart_pkg.sv | 20 ++
 rtl/sim_uart_rx.sv | 106 ++++++++++
 rtl/sim_uart_console.sv | 149 ++++++++++++++
 tb/tb_sim_uart_console.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_uart_pkg.sv
// sim_uart_pkg
//   Shared types and constants for the simulation UART console monitor.
//   rx_state_e : per-channel receiver states
//   CH_LF/CH_CR/CH_EOT : control bytes handled by the line buffer
//   OVERSAMPLE : ticks per bit period
package sim_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_EOT = 8'h04;
   localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/sim_uart_rx.sv
// sim_uart_rx
//   One 8N1 receiver: 2-FF synchroniser, 16x tick divider and RX FSM.
//   Ports:
//     sys_clk_i    clock, all logic on posedge
//     sys_rst_i    synchronous active-high reset
//     rx_i         asynchronous serial line (idle high)
//     data_o       last good byte, updates the cycle after the stop sample
//     valid_o      1-cycle pulse alongside a data_o update
//     frame_err_o  sticky, set when a stop bit is sampled low
module sim_uart_rx
   import sim_uart_pkg::*;
#(
   parameter logic [15:0] DIVISOR = 16'd43
) (
   input  logic       sys_clk_i,
   input  logic       sys_rst_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o
);

   rx_state_e   state_q;
   logic [1:0]  sync_q;
   logic [15:0] divCnt_q;
   logic [3:0]  tickIdx_q;
   logic [2:0]  bitIdx_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        frameErr_q;
   logic        tick;
   logic        rxSync;

   assign rxSync = sync_q[1];

   // A tick marks the end of each 1/16 bit period; the divider only runs
   // while a frame is in progress so the first tick is phase-aligned to
   // the start edge.
   assign tick = (divCnt_q == DIVISOR - 16'd1);

   // Receiver FSM. The synchroniser resets to idle-high so reset never
   // looks like a start edge. Tick index assignments inside the state
   // arms override the free-running increment when a bit is sampled.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         divCnt_q   <= '0;
         tickIdx_q  <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         valid_q <= 1'b0;
         if (state_q == IDLE) begin
            divCnt_q  <= '0;
            tickIdx_q <= '0;
         end else if (tick) begin
            divCnt_q  <= '0;
            tickIdx_q <= tickIdx_q + 4'd1;
         end else begin
            divCnt_q <= divCnt_q + 16'd1;
         end
         case (state_q)
            IDLE: begin
               if (!rxSync) state_q <= START;
            end
            START: begin
               if (tick && tickIdx_q == 4'd7) begin
                  tickIdx_q <= '0;
                  bitIdx_q  <= '0;
                  state_q   <= rxSync ? IDLE : DATA;
               end
            end
            DATA: begin
               if (tick && tickIdx_q == 4'd15) begin
                  shift_q  <= {rxSync, shift_q[7:1]};
                  bitIdx_q <= bitIdx_q + 3'd1;
                  if (bitIdx_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               if (tick && tickIdx_q == 4'd15) begin
                  if (rxSync) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                  end else begin
                     frameErr_q <= 1'b1;
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = frameErr_q;

endmodule

// File: rtl/sim_uart_console.sv
// sim_uart_console
//   Multi-channel UART console monitor: decodes N 8N1 lines and prints each
//   completed line atomically as "[chK] text\n".
//   Ports:
//     sys_clk_i, sys_rst_i  clock and synchronous active-high reset
//     uart_rx_i             CHANNELS serial lines (idle high)
//     rx_data_o             last byte per channel, ch K at [8K+7:8K]
//     rx_valid_o            per-channel byte pulse
//     line_done_o           per-channel flush pulse, same cycle as the byte
//     frame_err_o           sticky per-channel framing error
//     overflow_o            sticky per-channel line truncation
//     char_count_o          total valid bytes, wraps at 2^32
//     sim_exit_o            sticky EOT seen (only with SIM_UART_EXIT_EN)
//   Optional feature macro: SIM_UART_EXIT_EN (EOT byte ends the simulation
//   run by raising sim_exit_o; otherwise 0x04 is an ordinary byte).
module sim_uart_console
   import sim_uart_pkg::*;
#(
   parameter int          CHANNELS   = 1,
   parameter logic [15:0] DIVISOR    = 16'd43,
   parameter int          LINE_DEPTH = 128,
   parameter logic [31:0] STDOUT     = 32'h8000_0001
) (
   input  logic                  sys_clk_i,
   input  logic                  sys_rst_i,
   input  logic [CHANNELS-1:0]   uart_rx_i,
   output logic [CHANNELS*8-1:0] rx_data_o,
   output logic [CHANNELS-1:0]   rx_valid_o,
   output logic [CHANNELS-1:0]   line_done_o,
   output logic [CHANNELS-1:0]   frame_err_o,
   output logic [CHANNELS-1:0]   overflow_o,
   output logic [31:0]           char_count_o,
   output logic                  sim_exit_o
);

   localparam int CW = $clog2(LINE_DEPTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(LINE_DEPTH - 1);

   logic [7:0]          lineMem_q [CHANNELS][LINE_DEPTH];
   logic [CW-1:0]       lineCount_q [CHANNELS];
   logic [CHANNELS-1:0] overflow_q;
   logic [31:0]         charCount_q;
   logic [31:0]         charCount_d;
   logic [CHANNELS-1:0] store_d;
   logic [CHANNELS-1:0] flush_d;
   logic [CHANNELS-1:0] ovf_d;
   logic [CHANNELS-1:0] eot_d;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_rx
      sim_uart_rx #(.DIVISOR(DIVISOR)) u_rx (
         .sys_clk_i   (sys_clk_i),
         .sys_rst_i   (sys_rst_i),
         .rx_i        (uart_rx_i[c]),
         .data_o      (rx_data_o[c*8 +: 8]),
         .valid_o     (rx_valid_o[c]),
         .frame_err_o (frame_err_o[c])
      );
   end

   // Classify each arriving byte. A byte landing in the last slot is stored
   // and flushes in the same cycle, so a full line prints the moment it fills.
   always_comb begin
      store_d     = '0;
      flush_d     = '0;
      ovf_d       = '0;
      eot_d       = '0;
      charCount_d = charCount_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rx_valid_o[c]) begin
            charCount_d = charCount_d + 32'd1;
            if (rx_data_o[c*8 +: 8] == CH_LF) begin
               flush_d[c] = 1'b1;
`ifdef SIM_UART_EXIT_EN
            end else if (rx_data_o[c*8 +: 8] == CH_EOT) begin
               eot_d[c]   = 1'b1;
               flush_d[c] = (lineCount_q[c] != '0);
`endif
            end else if (rx_data_o[c*8 +: 8] != CH_CR) begin
               store_d[c] = 1'b1;
               if (lineCount_q[c] == LAST_IDX) begin
                  flush_d[c] = 1'b1;
                  ovf_d[c]   = 1'b1;
               end
            end
         end
      end
   end

   // Line counters and sticky flags; a flush takes priority over a store
   // so a truncated line restarts empty.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         for (int c = 0; c < CHANNELS; c++) lineCount_q[c] <= '0;
         overflow_q  <= '0;
         charCount_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (flush_d[c])      lineCount_q[c] <= '0;
            else if (store_d[c]) lineCount_q[c] <= lineCount_q[c] + 1'b1;
         end
         overflow_q  <= overflow_q | ovf_d;
         charCount_q <= charCount_d;
      end
   end

   // Line storage needs no reset: the counters decide what is valid.
   always_ff @(posedge sys_clk_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (store_d[c]) lineMem_q[c][lineCount_q[c]] <= rx_data_o[c*8 +: 8];
      end
   end

`ifdef SIM_UART_EXIT_EN
   logic simExit_q;

   // EOT latches until reset so the testbench can end the run at leisure.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) simExit_q <= 1'b0;
      else           simExit_q <= simExit_q | (|eot_d);
   end
   assign sim_exit_o = simExit_q;
`else
   assign sim_exit_o = 1'b0;
`endif

`ifndef SYNTHESIS
   // Printing reads the buffer before this edge's store lands, so the byte
   // that fills an overflowing line is appended explicitly. Channels print
   // in ascending order within the same cycle.
   always @(posedge sys_clk_i) begin
      if (!sys_rst_i && (|flush_d || |eot_d)) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (flush_d[c]) begin
               $write("[ch%0d] ", c);
               for (int i = 0; i < int'(lineCount_q[c]); i++) $write("%c", lineMem_q[c][i]);
               if (ovf_d[c]) $write("%c", rx_data_o[c*8 +: 8]);
               $write("\n");
            end
            if (eot_d[c]) $display("UART EOT ch%0d", c);
         end
      end
   end
`endif

   assign line_done_o  = flush_d;
   assign overflow_o   = overflow_q;
   assign char_count_o = charCount_q;

endmodule

// File: tb/tb_sim_uart_console.sv
// tb_sim_uart_console
//   Directed bench for sim_uart_console with two channels, a 4-cycle tick
//   divider and a 4-byte line buffer so overflow is reachable quickly.
module tb_sim_uart_console;

   localparam int CH  = 2;
   localparam int DIV = 4;
   localparam int BIT = 16 * DIV;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] uartRx = '1;
   logic [CH*8-1:0] rxData;
   logic [CH-1:0] rxValid, lineDone, frameErr, overflow;
   logic [31:0]   charCount;
   logic          simExit;

   int errors = 0;
   int checks = 0;

   int validCnt [CH];
   int doneCnt  [CH];
   logic [7:0] lastData [CH];
   int bothDone = 0;
   int orphanDone = 0;

   typedef struct {
      int         ch;
      logic [7:0] data;
      logic       stopOk;
      int         expValidInc;
      int         expDoneInc;
      logic [31:0] expCount;
      logic [1:0] expOvf;
      logic [1:0] expFerr;
   } vec_t;

   vec_t vecs[$];

   sim_uart_console #(
      .CHANNELS(CH), .DIVISOR(16'(DIV)), .LINE_DEPTH(4), .STDOUT(32'h8000_0001)
   ) dut (
      .sys_clk_i   (clk),
      .sys_rst_i   (rst),
      .uart_rx_i   (uartRx),
      .rx_data_o   (rxData),
      .rx_valid_o  (rxValid),
      .line_done_o (lineDone),
      .frame_err_o (frameErr),
      .overflow_o  (overflow),
      .char_count_o(charCount),
      .sim_exit_o  (simExit)
   );

   always #5 clk = ~clk;

   // Event monitor, sampled on the falling edge away from DUT updates.
   initial begin
      for (int c = 0; c < CH; c++) begin
         validCnt[c] = 0; doneCnt[c] = 0; lastData[c] = '0;
      end
      forever begin
         @(negedge clk);
         for (int c = 0; c < CH; c++) begin
            if (rxValid[c]) begin
               validCnt[c]++;
               lastData[c] = rxData[c*8 +: 8];
            end
            if (lineDone[c]) doneCnt[c]++;
            if (lineDone[c] && !rxValid[c]) orphanDone++;
         end
         if (&lineDone) bothDone++;
      end
   end

   function automatic vec_t mkVec(input int ch, input logic [7:0] d, input logic ok,
                                  input int vInc, input int dInc, input logic [31:0] cnt,
                                  input logic [1:0] ovf, input logic [1:0] ferr);
      vec_t v;
      v.ch = ch; v.data = d; v.stopOk = ok; v.expValidInc = vInc; v.expDoneInc = dInc;
      v.expCount = cnt; v.expOvf = ovf; v.expFerr = ferr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
      checks++;
      if (act !== expVal) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expVal);
      end
   endtask

   // A low stop bit is released early so the receiver's re-armed start
   // detector sees the line return high and treats it as a glitch.
   task automatic sendByte(input int ch, input logic [7:0] d, input logic stopBit);
      logic [9:0] frame;
      frame = {stopBit, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uartRx[ch] = frame[i];
         if (i == 9 && !stopBit) repeat (BIT * 3 / 4) @(negedge clk);
         else                    repeat (BIT) @(negedge clk);
      end
      uartRx[ch] = 1'b1;
      repeat (stopBit ? BIT : BIT + BIT / 4) @(negedge clk);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int v0, d0;
      v0 = validCnt[v.ch];
      d0 = doneCnt[v.ch];
      sendByte(v.ch, v.data, v.stopOk);
      checkOutput($sformatf("v%0d validInc", idx), 32'(validCnt[v.ch] - v0), 32'(v.expValidInc));
      if (v.expValidInc != 0)
         checkOutput($sformatf("v%0d data", idx), 32'(lastData[v.ch]), 32'(v.data));
      checkOutput($sformatf("v%0d doneInc", idx), 32'(doneCnt[v.ch] - d0), 32'(v.expDoneInc));
      checkOutput($sformatf("v%0d charCount", idx), charCount, v.expCount);
      checkOutput($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.expOvf));
      checkOutput($sformatf("v%0d frameErr", idx), 32'(frameErr), 32'(v.expFerr));
   endtask

   initial begin
      int d0, d1, b0;
      logic [7:0] msgA [3];
      logic [7:0] msgB [3];
      logic [7:0] partial [3];
      logic [7:0] ok [3];
      logic [7:0] v55;

      // "Hi\r\n", bad stop on 'A', "ABCDEF\n" with a 4-byte line, then ch1.
      vecs.push_back(mkVec(0, 8'h48, 1, 1, 0, 1, 2'b00, 2'b00));
      vecs.push_back(mkVec(0, 8'h69, 1, 1, 0, 2, 2'b00, 2'b00));
      vecs.push_back(mkVec(0, 8'h0D, 1, 1, 0, 3, 2'b00, 2'b00));
      vecs.push_back(mkVec(0, 8'h0A, 1, 1, 1, 4, 2'b00, 2'b00));
      vecs.push_back(mkVec(0, 8'h41, 0, 0, 0, 4, 2'b00, 2'b01));
      vecs.push_back(mkVec(0, 8'h41, 1, 1, 0, 5, 2'b00, 2'b01));
      vecs.push_back(mkVec(0, 8'h42, 1, 1, 0, 6, 2'b00, 2'b01));
      vecs.push_back(mkVec(0, 8'h43, 1, 1, 0, 7, 2'b00, 2'b01));
      vecs.push_back(mkVec(0, 8'h44, 1, 1, 1, 8, 2'b01, 2'b01));
      vecs.push_back(mkVec(0, 8'h45, 1, 1, 0, 9, 2'b01, 2'b01));
      vecs.push_back(mkVec(0, 8'h46, 1, 1, 0, 10, 2'b01, 2'b01));
      vecs.push_back(mkVec(0, 8'h0A, 1, 1, 1, 11, 2'b01, 2'b01));
      vecs.push_back(mkVec(1, 8'h5A, 1, 1, 0, 12, 2'b01, 2'b01));
      vecs.push_back(mkVec(1, 8'h0A, 1, 1, 1, 13, 2'b01, 2'b01));

      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset rxData", 32'(rxData), 32'h0);
      checkOutput("reset rxValid", 32'(rxValid), 32'h0);
      checkOutput("reset lineDone", 32'(lineDone), 32'h0);
      checkOutput("reset frameErr", 32'(frameErr), 32'h0);
      checkOutput("reset overflow", 32'(overflow), 32'h0);
      checkOutput("reset charCount", charCount, 32'h0);
      checkOutput("reset simExit", 32'(simExit), 32'h0);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

      // "aa\n" on ch1 and "bb\n" on ch0 in lockstep: both flush together.
      msgA = '{8'h61, 8'h61, 8'h0A};
      msgB = '{8'h62, 8'h62, 8'h0A};
      d0 = doneCnt[0]; d1 = doneCnt[1]; b0 = bothDone;
      for (int i = 0; i < 3; i++) begin
         fork
            sendByte(1, msgA[i], 1'b1);
            sendByte(0, msgB[i], 1'b1);
         join
      end
      checkOutput("dual sameCycle", 32'(bothDone - b0), 32'd1);
      checkOutput("dual done ch0", 32'(doneCnt[0] - d0), 32'd1);
      checkOutput("dual done ch1", 32'(doneCnt[1] - d1), 32'd1);
      checkOutput("dual charCount", charCount, 32'd19);

      // Leave "qrs" buffered, then reset in the middle of bit 3 of 0x55.
      partial = '{8'h71, 8'h72, 8'h73};
      for (int i = 0; i < 3; i++) sendByte(0, partial[i], 1'b1);
      checkOutput("partial charCount", charCount, 32'd22);
      v55 = 8'h55;
      uartRx[0] = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         uartRx[0] = v55[i];
         repeat (BIT) @(negedge clk);
      end
      uartRx[0] = v55[3];
      repeat (BIT / 2) @(negedge clk);
      rst = 1'b1;
      uartRx[0] = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset charCount", charCount, 32'd0);
      checkOutput("midreset overflow", 32'(overflow), 32'd0);
      checkOutput("midreset frameErr", 32'(frameErr), 32'd0);
      checkOutput("midreset rxData", 32'(rxData), 32'd0);
      repeat (BIT) @(negedge clk);
      ok = '{8'h6F, 8'h6B, 8'h0A};
      d0 = doneCnt[0];
      for (int i = 0; i < 3; i++) sendByte(0, ok[i], 1'b1);
      checkOutput("ok charCount", charCount, 32'd3);
      checkOutput("ok doneInc", 32'(doneCnt[0] - d0), 32'd1);
      checkOutput("ok overflow", 32'(overflow), 32'd0);
      checkOutput("ok frameErr", 32'(frameErr), 32'd0);
      checkOutput("ok lastData", 32'(lastData[0]), 32'h0A);

      // "x" then EOT.
      sendByte(0, 8'h78, 1'b1);
      d0 = doneCnt[0];
      sendByte(0, 8'h04, 1'b1);
      checkOutput("eot charCount", charCount, 32'd5);
      checkOutput("eot lastData", 32'(lastData[0]), 32'h04);
`ifdef SIM_UART_EXIT_EN
      checkOutput("eot doneInc", 32'(doneCnt[0] - d0), 32'd1);
      checkOutput("eot simExit", 32'(simExit), 32'd1);
`else
      checkOutput("eot doneInc", 32'(doneCnt[0] - d0), 32'd0);
      checkOutput("eot simExit", 32'(simExit), 32'd0);
`endif
      d0 = doneCnt[0];
      sendByte(0, 8'h0A, 1'b1);
      checkOutput("final doneInc", 32'(doneCnt[0] - d0), 32'd1);
      checkOutput("final charCount", charCount, 32'd6);
      checkOutput("lineDone without byte", 32'(orphanDone), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
